wb_write_queue: RTL and testbench
=================================

Name: wb_write_queue

Overview:
- Writeback stage directly upstream of the 16x32 register file.
- Accepts write results from the ALU and from the load path, buffers them in a small in-order FIFO, and drains them one at a time onto the register file's edge-triggered write port.
- Exports a per-register pending mask for hazard stalls and an optional youngest-value forwarding lookup.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- DATA_W, 32, write data width.
- ADDR_W, 4, register index width; the register count is 2**ADDR_W.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- alu_valid  input  1  ALU write request this cycle.
- alu_addr  input  ADDR_W  ALU destination register.
- alu_data  input  DATA_W  ALU result.
- ld_valid  input  1  load write request this cycle.
- ld_addr  input  ADDR_W  load destination register.
- ld_data  input  DATA_W  load data.
- in_ready  output  1  both sources may present a request this cycle.
- rf_we  output  1  register-file write strobe; rising edge commits the write.
- rf_waddr  output  ADDR_W  register-file write address.
- rf_wdata  output  DATA_W  register-file write data.
- pending  output  2**ADDR_W  bit r set while any queued or in-flight write targets r.
- occupancy  output  clog2(DEPTH)+1  entries held in the FIFO, excluding the in-flight write.
- overflow  output  1  sticky error flag.
- fwd_addr  input  ADDR_W  forwarding lookup address.
- fwd_hit  output  1  a pending write to fwd_addr exists.
- fwd_data  output  DATA_W  data of the youngest pending write to fwd_addr.

Behaviour:
- Reset (asynchronous, active-low):
  - FIFO emptied; head pointer, tail pointer and occupancy cleared.
  - rf_we=0, rf_waddr=0, rf_wdata=0, pending=0, overflow=0, FSM=IDLE.
  - Reset asserted mid-drain aborts the in-flight write: rf_we falls immediately.
- in_ready = (DEPTH - occupancy) >= 2, computed from registered state only. A same-cycle pop does not raise it.
- Enqueue at a rising edge with in_ready=1:
  - If both valid: the ALU entry is enqueued first (older), then the load entry.
  - If only one valid: one entry is enqueued.
- Any valid request while in_ready=0 is dropped and sets overflow. overflow stays set until reset.
- Drain FSM has three states:
  - IDLE: if the FIFO is non-empty, pop the head into rf_waddr/rf_wdata, set rf_we=1, go to WRITE.
  - WRITE: rf_we held high exactly one cycle; next state GAP with rf_we=0.
  - GAP: rf_we low one cycle, because the register file needs a fresh rising edge per write. If the FIFO is non-empty, pop the head, set rf_we=1 and go to WRITE; otherwise go to IDLE.
  - Peak throughput: one write per 2 cycles.
- Latency: an entry enqueued at edge N into an empty queue with FSM in IDLE raises rf_we at edge N+1.
- Push and pop at the same edge are both performed; occupancy = old + pushes - pop.
- Pointers wrap modulo DEPTH.
- pending[r]: OR over valid FIFO entries with addr r, plus the in-flight entry (rf_waddr while in WRITE or GAP).
  - Recomputed combinationally from registered state.
  - Bit clears the cycle after the last matching write leaves GAP.
- Duplicate destinations are legal and commit in order; the youngest value persists in the register file.
- Register 0 is an ordinary register: writes to it are queued and committed.

Optional Feature:
- Macro WB_FWD_EN.
- Defined:
  - fwd_hit/fwd_data are combinational over FIFO entries plus the in-flight entry.
  - The youngest match wins; a FIFO entry is younger than the in-flight entry.
  - Within the FIFO, nearer to tail means younger.
- Undefined:
  - Ports remain present; fwd_hit=0 and fwd_data=0 constantly.
  - The match logic is not instantiated.

Test Plan:
- Reset with reset_n=0 mid-drain (rf_we=1) -> rf_we, pending, occupancy and overflow read 0 immediately, without waiting for a clock edge.
- Single ALU write r3=0x11112222 into an idle queue -> rf_we high for exactly 1 cycle, starting the edge after enqueue, with rf_waddr=3 and rf_wdata=0x11112222. pending[3] is set from enqueue until after GAP, then 0.
- Same-cycle ALU r5=0xA and load r5=0xB -> two rf_we pulses separated by one low cycle, committing 0xA then 0xB. With WB_FWD_EN, fwd_addr=5 gives fwd_hit=1 and fwd_data=0xB while both entries are pending.
- Fill to occupancy 3 (DEPTH=4) -> in_ready=0. Asserting alu_valid then sets overflow=1, the entry is not stored, and overflow stays 1 after the queue drains.
- Continuous dual-source pushes until the queue is full -> pointers wrap, every accepted write appears on rf_w* in acceptance order, and no rf_we pulse is wider than 1 cycle.
- Without WB_FWD_EN, repeat the r5 scenario -> fwd_hit=0 and fwd_data=0 throughout; the commit order is unchanged.

Source files
------------

// File: rtl/wb_write_queue_if.sv
// wb_write_queue_if: source, register-file, hazard and forwarding signals of the writeback queue
interface wb_write_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic                    alu_valid;
  logic [ADDR_W-1:0]       alu_addr;
  logic [DATA_W-1:0]       alu_data;
  logic                    ld_valid;
  logic [ADDR_W-1:0]       ld_addr;
  logic [DATA_W-1:0]       ld_data;
  logic                    in_ready;
  logic                    rf_we;
  logic [ADDR_W-1:0]       rf_waddr;
  logic [DATA_W-1:0]       rf_wdata;
  logic [2**ADDR_W-1:0]    pending;
  logic [$clog2(DEPTH):0]  occupancy;
  logic                    overflow;
  logic [ADDR_W-1:0]       fwd_addr;
  logic                    fwd_hit;
  logic [DATA_W-1:0]       fwd_data;
  modport slave (
    input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data, fwd_addr,
    output in_ready, rf_we, rf_waddr, rf_wdata, pending, occupancy, overflow, fwd_hit, fwd_data
  );
  modport master (
    output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data, fwd_addr,
    input  in_ready, rf_we, rf_waddr, rf_wdata, pending, occupancy, overflow, fwd_hit, fwd_data
  );
endinterface

// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order writeback FIFO draining one write per two cycles; WB_FWD_EN enables youngest-value forwarding
module wb_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  wb_write_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int NR = 2**ADDR_W;
  localparam logic [PW:0] LIM = (PW+1)'(DEPTH - 2);
  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;
  state_t            state_q, state_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d, ld_slot;
  logic [PW:0]       occ_q, occ_d, n_push;
  logic              overflow_q, overflow_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              in_ready, push_a, push_l, pop;
  logic [NR-1:0]     pend;
  logic              hit;
  logic [DATA_W-1:0] fdata;
  assign in_ready = occ_q <= LIM;
  assign push_a   = bus.alu_valid & in_ready;
  assign push_l   = bus.ld_valid & in_ready;
  assign n_push   = (PW+1)'(push_a) + (PW+1)'(push_l);
  assign pop      = state_q != WRITE && occ_q != '0;
  assign ld_slot  = tail_q + PW'(push_a);
  // Next state: drain FSM, pointer/occupancy bookkeeping and sticky overflow
  always_comb begin
    state_d    = state_q == WRITE ? GAP : pop ? WRITE : IDLE;
    waddr_d    = pop ? addr_mem[head_q] : waddr_q;
    wdata_d    = pop ? data_mem[head_q] : wdata_q;
    head_d     = head_q + PW'(pop);
    tail_d     = tail_q + n_push[PW-1:0];
    occ_d      = occ_q + n_push - (PW+1)'(pop);
    overflow_d = overflow_q | ((bus.alu_valid | bus.ld_valid) & ~in_ready);
  end
  // Control state; reset aborts an in-flight write at once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end
  // Entry storage; the ALU entry takes the older slot when both sources push
  always_ff @(posedge clock) begin
    if (push_a) begin
      addr_mem[tail_q] <= bus.alu_addr;
      data_mem[tail_q] <= bus.alu_data;
    end
    if (push_l) begin
      addr_mem[ld_slot] <= bus.ld_addr;
      data_mem[ld_slot] <= bus.ld_data;
    end
  end
  // Pending mask over live FIFO slots plus the write still in WRITE or GAP
  always_comb begin
    pend = '0;
    for (int k = 0; k < DEPTH; k++)
      if ((PW+1)'(k) < occ_q) pend[addr_mem[head_q + PW'(k)]] = 1'b1;
    if (state_q != IDLE) pend[waddr_q] = 1'b1;
  end
`ifdef WB_FWD_EN
  // Forwarding: in-flight entry is oldest, then FIFO from head to tail so the youngest match wins
  always_comb begin
    hit   = state_q != IDLE && waddr_q == bus.fwd_addr;
    fdata = hit ? wdata_q : '0;
    for (int k = 0; k < DEPTH; k++)
      if ((PW+1)'(k) < occ_q && addr_mem[head_q + PW'(k)] == bus.fwd_addr) begin
        hit   = 1'b1;
        fdata = data_mem[head_q + PW'(k)];
      end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^bus.fwd_addr;
  assign hit        = 1'b0;
  assign fdata      = '0;
`endif
  assign bus.in_ready  = in_ready;
  assign bus.rf_we     = state_q == WRITE;
  assign bus.rf_waddr  = waddr_q;
  assign bus.rf_wdata  = wdata_q;
  assign bus.pending   = pend;
  assign bus.occupancy = occ_q;
  assign bus.overflow  = overflow_q;
  assign bus.fwd_hit   = hit;
  assign bus.fwd_data  = fdata;
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: queue-level model compared every cycle, plus directed literal checks
module tb_wb_write_queue;
  localparam int DEPTH = 4;
  typedef struct { logic [3:0] a; logic [31:0] d; } ent_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int tests = 0;
  int fails = 0;
  wb_write_queue_if #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(4)) bus ();
  wb_write_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(4)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  ent_t mq[$];
  ent_t cur;
  ent_t commits[$];
  ent_t expq[$];
  int   cyc, pop_cyc;
  bit   movf;
  bit   prev_we;
  function automatic bit mready();
    return (DEPTH - mq.size()) >= 2;
  endfunction
  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask
  // model: queue of accepted writes; a write is visible on rf_w* in the cycle right after its pop
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      cur = '{a: 4'd0, d: 32'd0};
      cyc = 0;
      pop_cyc = -10;
      movf = 0;
    end else begin
      bit rdy, dp;
      rdy = mready();
      dp = mq.size() > 0 && cyc != pop_cyc;
      cyc++;
      if (dp) begin
        cur = mq.pop_front();
        pop_cyc = cyc;
      end
      if (bus.alu_valid) begin
        if (rdy) mq.push_back('{a: bus.alu_addr, d: bus.alu_data}); else movf = 1;
      end
      if (bus.ld_valid) begin
        if (rdy) mq.push_back('{a: bus.ld_addr, d: bus.ld_data}); else movf = 1;
      end
    end
  end
  // compare every cycle on the falling edge
  always @(negedge clock) begin
    logic [15:0] ep;
    bit inf, eh;
    logic [31:0] ed;
    inf = (cyc - pop_cyc) <= 1;
    ep = '0;
    foreach (mq[i]) ep[mq[i].a] = 1'b1;
    if (inf) ep[cur.a] = 1'b1;
    eh = 0;
    ed = '0;
`ifdef WB_FWD_EN
    if (inf && cur.a == bus.fwd_addr) begin eh = 1; ed = cur.d; end
    foreach (mq[i]) if (mq[i].a == bus.fwd_addr) begin eh = 1; ed = mq[i].d; end
`endif
    chk("in_ready", bus.in_ready, mready());
    chk("rf_we", bus.rf_we, cyc == pop_cyc);
    chk("rf_waddr", bus.rf_waddr, cur.a);
    chk("rf_wdata", bus.rf_wdata, cur.d);
    chk("pending", bus.pending, ep);
    chk("occupancy", bus.occupancy, mq.size());
    chk("overflow", bus.overflow, movf);
    chk("fwd_hit", bus.fwd_hit, eh);
    chk("fwd_data", bus.fwd_data, ed);
    chk("we_width", prev_we & bus.rf_we, 1'b0);
    prev_we = bus.rf_we;
    if (bus.rf_we && reset_n) commits.push_back('{a: bus.rf_waddr, d: bus.rf_wdata});
  end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic drive(bit av, logic [3:0] aa, logic [31:0] ad, bit lv, logic [3:0] la, logic [31:0] ld);
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.ld_valid = lv; bus.ld_addr = la; bus.ld_data = ld;
    step();
    bus.alu_valid = 0;
    bus.ld_valid = 0;
  endtask
  initial begin
    bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_data = 0;
    bus.ld_valid = 0; bus.ld_addr = 0; bus.ld_data = 0;
    bus.fwd_addr = 4'd5;
    #2;
    chk("rst_we", bus.rf_we, 1'b0);
    chk("rst_occ", bus.occupancy, 0);
    chk("rst_ready", bus.in_ready, 1'b1);
    #10 reset_n = 1'b1;
    step();
    // single ALU write r3
    drive(1, 4'd3, 32'h11112222, 0, 4'd0, 32'd0);
    chk("s1_pend_enq", bus.pending[3], 1'b1);
    chk("s1_occ", bus.occupancy, 1);
    chk("s1_we_pre", bus.rf_we, 1'b0);
    step();
    chk("s1_we", bus.rf_we, 1'b1);
    chk("s1_addr", bus.rf_waddr, 4'd3);
    chk("s1_data", bus.rf_wdata, 32'h11112222);
    step();
    chk("s1_gap_we", bus.rf_we, 1'b0);
    chk("s1_gap_pend", bus.pending[3], 1'b1);
    step();
    chk("s1_pend_clr", bus.pending[3], 1'b0);
    // same-cycle r5 pair
    drive(1, 4'd5, 32'hA, 1, 4'd5, 32'hB);
    chk("s2_occ", bus.occupancy, 2);
`ifdef WB_FWD_EN
    chk("s2_hit", bus.fwd_hit, 1'b1);
    chk("s2_fdata", bus.fwd_data, 32'hB);
`else
    chk("s2_hit", bus.fwd_hit, 1'b0);
    chk("s2_fdata", bus.fwd_data, 32'h0);
`endif
    step();
    chk("s2_we1", bus.rf_we, 1'b1);
    chk("s2_d1", bus.rf_wdata, 32'hA);
    step();
    chk("s2_gap", bus.rf_we, 1'b0);
    step();
    chk("s2_we2", bus.rf_we, 1'b1);
    chk("s2_d2", bus.rf_wdata, 32'hB);
    step();
    step();
    chk("s2_pend_clr", bus.pending[5], 1'b0);
    // fill to 3 then overflow
    commits.delete();
    drive(1, 4'd1, 32'h1, 1, 4'd2, 32'h2);
    drive(1, 4'd6, 32'h6, 1, 4'd7, 32'h7);
    chk("s3_occ3", bus.occupancy, 3);
    chk("s3_notready", bus.in_ready, 1'b0);
    chk("s3_ovf0", bus.overflow, 1'b0);
    drive(1, 4'd8, 32'h8, 0, 4'd0, 32'd0);
    chk("s3_ovf1", bus.overflow, 1'b1);
    chk("s3_occ_kept", bus.occupancy, 3);
    repeat (12) step();
    chk("s3_drained", bus.occupancy, 0);
    chk("s3_ovf_sticky", bus.overflow, 1'b1);
    chk("s3_pend0", bus.pending, 16'h0);
    chk("s3_ncommit", commits.size(), 4);
    if (commits.size() == 4) chk("s3_last", commits[3].a, 4'd7);
    // continuous dual pushes with wrap
    commits.delete();
    expq.delete();
    for (int k = 0; k < 24; k++) begin
      if (mready()) begin
        expq.push_back('{a: 4'(2*k), d: 32'hC0DE0000 + 32'(2*k)});
        expq.push_back('{a: 4'(2*k+1), d: 32'hC0DE0000 + 32'(2*k+1)});
        drive(1, 4'(2*k), 32'hC0DE0000 + 32'(2*k), 1, 4'(2*k+1), 32'hC0DE0000 + 32'(2*k+1));
      end else step();
    end
    repeat (20) step();
    chk("s4_ncommit", commits.size(), expq.size());
    chk("s4_enough", expq.size() > 8, 1'b1);
    foreach (expq[i]) if (i < commits.size()) chk("s4_order", {commits[i].a, commits[i].d}, {expq[i].a, expq[i].d});
    // reset mid-drain
    drive(1, 4'd9, 32'h9, 1, 4'd10, 32'h10);
    drive(1, 4'd11, 32'h11, 0, 4'd0, 32'd0);
    for (int i = 0; i < 10 && !bus.rf_we; i++) step();
    chk("s5_we_before", bus.rf_we, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("s5_we", bus.rf_we, 1'b0);
    chk("s5_pend", bus.pending, 16'h0);
    chk("s5_occ", bus.occupancy, 0);
    chk("s5_ovf", bus.overflow, 1'b0);
    #3 reset_n = 1'b1;
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
